// File: rtl/rs_pkg.sv
// Shared constants, FSM encoding and log-domain arithmetic for the RS(204,188)
// Chien search.
package rs_pkg;

  localparam int N     = 204;
  localparam int T     = 8;
  localparam int SHORT = 51;

  localparam logic [7:0] LOG_ZERO = 8'd0;

  // alpha^((SHORT+1)*k) mod 255 for k = 1..T: places term k at byte index 0
  localparam logic [7:0] LOAD_OFF [T] = '{
    8'd52, 8'd104, 8'd156, 8'd208, 8'd5, 8'd57, 8'd109, 8'd161
  };

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  function automatic logic [7:0] gf_log_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (a == LOG_ZERO || b == LOG_ZERO) return LOG_ZERO;
    if (s > 9'd255) s = s - 9'd255;
    return s[7:0];
  endfunction

endpackage

// File: rtl/Alpha_To_Tuple.sv
// Log-format to polynomial-basis converter (x^8+x^4+x^3+x^2+1).
// Code 0 is the zero element; code 255 is alpha^0 = 8'h01.
module Alpha_To_Tuple (
  input  logic [7:0] alpha_i,
  output logic [7:0] tuple_o
);

  function automatic logic [2047:0] gen_exp();
    logic [7:0]    v;
    logic [2047:0] t;
    t = '0;
    v = 8'h01;
    for (int k = 1; k < 256; k++) begin
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
      t[k*8 +: 8] = v;
    end
    return t;
  endfunction

  localparam logic [2047:0] EXP_TBL = gen_exp();

  assign tuple_o = EXP_TBL[{alpha_i, 3'b000} +: 8];

endmodule

// File: rtl/rs_chien_cell.sv
// One Chien term: loads Sigma_k scaled to byte index 0, then steps by alpha^k
// per position; presents the term in tuple form.
module rs_chien_cell
  import rs_pkg::*;
#(
  parameter int K = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] sigma_i,
  output logic [7:0] tuple_o
);

  logic [7:0] term_q, term_d;

  always_comb begin
    term_d = term_q;
    if (load_i)      term_d = gf_log_mul(sigma_i, LOAD_OFF[K-1]);
    else if (step_i) term_d = gf_log_mul(term_q, 8'(K));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) term_q <= LOG_ZERO;
    else       term_q <= term_d;
  end

  Alpha_To_Tuple u_a2t (
    .alpha_i (term_q),
    .tuple_o (tuple_o)
  );

endmodule

// File: rtl/rs_chien_search.sv
// Chien search for the DVB-T RS(204,188) decoder: one codeword position per
// clock, flags roots of the error locator, then reports root count and failure.
module rs_chien_search
  import rs_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Sigma1,
  input  logic [7:0] Sigma2,
  input  logic [7:0] Sigma3,
  input  logic [7:0] Sigma4,
  input  logic [7:0] Sigma5,
  input  logic [7:0] Sigma6,
  input  logic [7:0] Sigma7,
  input  logic [7:0] Sigma8,
  output logic       Busy,
  output logic       Err_Valid,
  output logic       Err_Flag,
  output logic [7:0] Err_Pos,
  output logic       Done,
  output logic [7:0] Err_Count,
  output logic       Fail,
  output logic [1:0] Dbg_State
);

  // Start is a one-cycle request, honoured only in IDLE; there is no
  // backpressure: Err_Valid qualifies Err_Flag/Err_Pos for exactly one cycle.

  logic [1:0] state_q, state_d;
  logic [7:0] sigma_q [T];
  logic [7:0] sigma_d [T];
  logic [7:0] sigma_in [T];
  logic [3:0] deg_q, deg_d, deg_in;
  logic [7:0] pos_q, pos_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
  logic       flag_q, flag_d;
  logic [7:0] errpos_q, errpos_d;
  logic       done_q, done_d;
  logic [7:0] count_q, count_d;
  logic       fail_q, fail_d;

  logic [7:0] tuple_w [T];
  logic [7:0] sum;
  logic       load_w, step_w;

  assign sigma_in = '{Sigma1, Sigma2, Sigma3, Sigma4, Sigma5, Sigma6, Sigma7, Sigma8};
  assign load_w   = (state_q == ST_LOAD);
  assign step_w   = (state_q == ST_SEARCH);

  for (genvar k = 0; k < T; k++) begin : g_cell
    rs_chien_cell #(.K(k + 1)) u_cell (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .load_i  (load_w),
      .step_i  (step_w),
      .sigma_i (sigma_q[k]),
      .tuple_o (tuple_w[k])
    );
  end

  always_comb begin
    deg_in = 4'd0;
    for (int k = 0; k < T; k++)
      if (sigma_in[k] != LOG_ZERO) deg_in = 4'(k + 1);
  end

  // sigma0 = 1 contributes the constant 8'h01
  always_comb begin
    sum = 8'h01;
    for (int k = 0; k < T; k++) sum = sum ^ tuple_w[k];
  end

  always_comb begin
    state_d  = state_q;
    sigma_d  = sigma_q;
    deg_d    = deg_q;
    pos_d    = pos_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    flag_d   = 1'b0;
    errpos_d = errpos_q;
    done_d   = 1'b0;
    count_d  = count_q;
    fail_d   = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          sigma_d = sigma_in;
          deg_d   = deg_in;
          count_d = 8'd0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pos_d   = 8'd0;
        state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        valid_d  = 1'b1;
        flag_d   = (sum == 8'h00);
        errpos_d = pos_q;
        if (flag_d && count_q != 8'd255) count_d = count_q + 8'd1;
        pos_d = pos_q + 8'd1;
        if (pos_q == 8'(N - 1)) state_d = ST_FINISH;
      end
      default: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        fail_d  = (count_q != {4'd0, deg_q});
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      sigma_q  <= '{default: LOG_ZERO};
      deg_q    <= 4'd0;
      pos_q    <= 8'd0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      flag_q   <= 1'b0;
      errpos_q <= 8'd0;
      done_q   <= 1'b0;
      count_q  <= 8'd0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sigma_q  <= sigma_d;
      deg_q    <= deg_d;
      pos_q    <= pos_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      flag_q   <= flag_d;
      errpos_q <= errpos_d;
      done_q   <= done_d;
      count_q  <= count_d;
      fail_q   <= fail_d;
    end
  end

  assign Busy      = busy_q;
  assign Err_Valid = valid_q;
  assign Err_Flag  = flag_q;
  assign Err_Pos   = errpos_q;
  assign Done      = done_q;
  assign Err_Count = count_q;
  assign Fail      = fail_q;
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_rs_chien_search.sv
// Directed bench for rs_chien_search: table of locator vectors with
// hand-derived root positions, plus restart-while-busy and mid-search reset.
module tb_rs_chien_search;

  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic [7:0] Sigma1, Sigma2, Sigma3, Sigma4, Sigma5, Sigma6, Sigma7, Sigma8;
  logic       Busy, Err_Valid, Err_Flag, Done, Fail;
  logic [7:0] Err_Pos, Err_Count;
  logic [1:0] Dbg_State;

  always #5 Clk = ~Clk;

  rs_chien_search dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Sigma1    (Sigma1),
    .Sigma2    (Sigma2),
    .Sigma3    (Sigma3),
    .Sigma4    (Sigma4),
    .Sigma5    (Sigma5),
    .Sigma6    (Sigma6),
    .Sigma7    (Sigma7),
    .Sigma8    (Sigma8),
    .Busy      (Busy),
    .Err_Valid (Err_Valid),
    .Err_Flag  (Err_Flag),
    .Err_Pos   (Err_Pos),
    .Done      (Done),
    .Err_Count (Err_Count),
    .Fail      (Fail),
    .Dbg_State (Dbg_State)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];
  logic [7:0] exp_tbl [256];

  typedef struct {
    logic [7:0][7:0] sig;
    logic [7:0]      pa;
    logic [7:0]      pb;
    logic [7:0]      cnt;
    logic            fl;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] log_of(input logic [7:0] v);
    logic [7:0] r;
    r = 8'd0;
    for (int k = 1; k < 256; k++)
      if (exp_tbl[k] == v) r = 8'(k);
    return r;
  endfunction

  task automatic set_sigma(input logic [7:0][7:0] s);
    Sigma1 = s[0]; Sigma2 = s[1]; Sigma3 = s[2]; Sigma4 = s[3];
    Sigma5 = s[4]; Sigma6 = s[5]; Sigma7 = s[6]; Sigma8 = s[7];
  endtask

  task automatic drive_start(input logic [7:0][7:0] s);
    set_sigma(s);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("busy_after_start", {31'd0, Busy}, 32'd1);
    check("valid_after_start", {31'd0, Err_Valid}, 32'd0);
  endtask

  task automatic load_exp(input logic [7:0] pa, input logic [7:0] pb);
    exp_q.delete();
    for (int p = 0; p < 204; p++)
      exp_q.push_back({(8'(p) == pa || 8'(p) == pb), 8'(p)});
  endtask

  task automatic collect(input logic [7:0] ecnt, input logic efl,
                         input bit poke, input logic [7:0][7:0] poke_sig);
    int  nv;
    bit  got_done;
    bit  poked;
    logic [8:0] e;
    nv = 0; got_done = 1'b0; poked = 1'b0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      @(posedge Clk); #1;
      if (Err_Valid) begin
        if (exp_q.size() == 0) begin
          check("extra_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_flag", {31'd0, Err_Flag}, {31'd0, e[8]});
          check("err_pos", {24'd0, Err_Pos}, {24'd0, e[7:0]});
        end
        nv++;
      end
      if (Done) got_done = 1'b1;
      if (poke && !poked && nv == 50) begin
        set_sigma(poke_sig);
        Start  = 1'b1;
        poked  = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("valid_cycles", nv, 32'd204);
    check("err_count", {24'd0, Err_Count}, {24'd0, ecnt});
    check("fail", {31'd0, Fail}, {31'd0, efl});
    check("busy_at_done", {31'd0, Busy}, 32'd0);
    check("valid_at_done", {31'd0, Err_Valid}, 32'd0);
    @(posedge Clk); #1;
    check("done_pulse", {31'd0, Done}, 32'd0);
    check("count_held", {24'd0, Err_Count}, {24'd0, ecnt});
    check("fail_held", {31'd0, Fail}, {31'd0, efl});
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0][7:0] s;
    int  nv;
    bit  bad;

    v = 8'h01;
    exp_tbl[0] = 8'h00;
    for (int k = 1; k < 256; k++) begin
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
      exp_tbl[k] = v;
    end

    // all zero: no roots
    vecs[0] = '{sig: '0, pa: 8'hFF, pb: 8'hFF, cnt: 8'd0, fl: 1'b0};
    // single error at degree 203 -> position 0
    vecs[1] = '{sig: '0, pa: 8'd0, pb: 8'hFF, cnt: 8'd1, fl: 1'b0};
    vecs[1].sig[0] = 8'd203;
    // errors at degrees 3 and 7 -> positions 200 and 196
    vecs[2] = '{sig: '0, pa: 8'd196, pb: 8'd200, cnt: 8'd2, fl: 1'b0};
    vecs[2].sig[0] = log_of(exp_tbl[3] ^ exp_tbl[7]);
    vecs[2].sig[1] = 8'd10;
    // root at degree 210, outside the shortened range
    vecs[3] = '{sig: '0, pa: 8'hFF, pb: 8'hFF, cnt: 8'd0, fl: 1'b1};
    vecs[3].sig[0] = 8'd210;
    // root at degree 0 -> last position 203
    vecs[4] = '{sig: '0, pa: 8'd203, pb: 8'hFF, cnt: 8'd1, fl: 1'b0};
    vecs[4].sig[0] = 8'd255;

    Reset = 1'b1; Start = 1'b0;
    set_sigma('0);
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_valid", {31'd0, Err_Valid}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_count", {24'd0, Err_Count}, 32'd0);
    check("rst_fail", {31'd0, Fail}, 32'd0);
    check("rst_state", {30'd0, Dbg_State}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      load_exp(vecs[i].pa, vecs[i].pb);
      drive_start(vecs[i].sig);
      collect(vecs[i].cnt, vecs[i].fl, 1'b0, '0);
    end

    // Start while busy must not disturb the running search
    load_exp(vecs[2].pa, vecs[2].pb);
    drive_start(vecs[2].sig);
    collect(vecs[2].cnt, vecs[2].fl, 1'b1, vecs[1].sig);

    // reset in the middle of a search
    drive_start(vecs[2].sig);
    nv = 0;
    for (int cyc = 0; cyc < 300 && nv < 100; cyc++) begin
      @(posedge Clk); #1;
      if (Err_Valid) nv++;
    end
    check("pre_reset_valids", nv, 32'd100);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_valid", {31'd0, Err_Valid}, 32'd0);
    check("abort_flag", {31'd0, Err_Flag}, 32'd0);
    check("abort_pos", {24'd0, Err_Pos}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    check("abort_count", {24'd0, Err_Count}, 32'd0);
    check("abort_fail", {31'd0, Fail}, 32'd0);
    check("abort_state", {30'd0, Dbg_State}, 32'd0);
    bad = 1'b0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(posedge Clk); #1;
      if (Done || Err_Valid || Busy) bad = 1'b1;
    end
    check("no_activity_after_abort", {31'd0, bad}, 32'd0);

    s = vecs[2].sig;
    load_exp(vecs[2].pa, vecs[2].pb);
    drive_start(s);
    collect(vecs[2].cnt, vecs[2].fl, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
